// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage
// Description : Issues in-order instruction memory requests for the PC stage.
//               It tracks outstanding fetches and buffers returned words in a
//               small FIFO for the decode stage. It also applies back-pressure
//               to the PC stage and squashes wrong-path responses after a flush.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    FIFO_DEPTH      = 2,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD        = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  pc_valid,
    input  logic                  clear_instruction_fetch_stage,
    input  logic                  stall_instruction_fetch_stage,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] pc_fetched,
    output logic                  instruction_valid,
    output logic                  stall_programe_counter_stage
);

    localparam int c_os_w = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_tq_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_fp_w = $clog2(FIFO_DEPTH);
    localparam int c_fc_w = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_os_w-1:0] c_os_one  = c_os_w'(1);
    localparam logic [c_tq_w-1:0] c_tq_one  = c_tq_w'(1);
    localparam logic [c_tq_w-1:0] c_tq_last = c_tq_w'(MAX_OUTSTANDING - 1);
    localparam logic [c_fp_w-1:0] c_fp_one  = c_fp_w'(1);
    localparam logic [c_fc_w-1:0] c_fc_one  = c_fc_w'(1);

    // Request bookkeeping
    logic [c_os_w-1:0]     r_outstanding;
    logic [c_os_w-1:0]     r_kill;
    logic [c_os_w-1:0]     w_outstanding_nxt;

    // In-order PC tag queue (one entry per granted request)
    logic [ADDR_WIDTH-1:0] r_tag_q [MAX_OUTSTANDING];
    logic [c_tq_w-1:0]     r_tag_wr;
    logic [c_tq_w-1:0]     r_tag_rd;

    // Output FIFO
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [c_fp_w-1:0]     r_fifo_wr;
    logic [c_fp_w-1:0]     r_fifo_rd;
    logic [c_fc_w-1:0]     r_fifo_count;

    logic w_credit;
    logic w_fire;
    logic w_rsp;
    logic w_push;
    logic w_pop;
    logic w_valid;

    function automatic logic [c_tq_w-1:0] tq_next(input logic [c_tq_w-1:0] p);
        return (p == c_tq_last) ? '0 : p + c_tq_one;
    endfunction

    // Credit counts killed-but-unreturned requests too, so the FIFO can never overflow
    assign w_credit = ((32'(r_outstanding) + 32'(r_fifo_count)) < FIFO_DEPTH) &&
                      (32'(r_outstanding) < MAX_OUTSTANDING);

    assign imem_req  = pc_valid && w_credit && !clear_instruction_fetch_stage && !rst;
    assign imem_addr = pc;
    assign w_fire    = imem_req && imem_gnt;

    assign stall_programe_counter_stage = pc_valid && !w_fire;

    // A response with nothing outstanding is stray and is ignored entirely
    assign w_rsp   = imem_rvalid && (r_outstanding != '0);
    assign w_push  = w_rsp && (r_kill == '0) && !clear_instruction_fetch_stage;
    assign w_valid = (r_fifo_count != '0);
    assign w_pop   = w_valid && !stall_instruction_fetch_stage && !clear_instruction_fetch_stage;

    // Outstanding count after this cycle's grant and response
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_fire && !w_rsp) begin
            w_outstanding_nxt = r_outstanding + c_os_one;
        end else if (!w_fire && w_rsp) begin
            w_outstanding_nxt = r_outstanding - c_os_one;
        end
    end

    // Outstanding and kill counters; a flush marks every still-pending request as wrong-path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_kill        <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (clear_instruction_fetch_stage) begin
                r_kill <= w_outstanding_nxt;
            end else if (w_rsp && (r_kill != '0)) begin
                r_kill <= r_kill - c_os_one;
            end
        end
    end

    // Tag queue pointers: push on grant, pop on every accepted response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else begin
            if (w_fire) begin
                r_tag_wr <= tq_next(r_tag_wr);
            end
            if (w_rsp) begin
                r_tag_rd <= tq_next(r_tag_rd);
            end
        end
    end

    // Tag queue storage
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_tag_q[r_tag_wr] <= pc;
        end
    end

    // FIFO pointers and occupancy; a flush empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_wr    <= '0;
            r_fifo_rd    <= '0;
            r_fifo_count <= '0;
        end else if (clear_instruction_fetch_stage) begin
            r_fifo_wr    <= '0;
            r_fifo_rd    <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_wr <= r_fifo_wr + c_fp_one;
            end
            if (w_pop) begin
                r_fifo_rd <= r_fifo_rd + c_fp_one;
            end
            if (w_push && !w_pop) begin
                r_fifo_count <= r_fifo_count + c_fc_one;
            end else if (!w_push && w_pop) begin
                r_fifo_count <= r_fifo_count - c_fc_one;
            end
        end
    end

    // FIFO storage: returned word tagged with its request PC
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_fifo_wr] <= imem_rdata;
            r_fifo_pc[r_fifo_wr]   <= r_tag_q[r_tag_rd];
        end
    end

    // Present FIFO head, or a NOP bubble when empty
    always_comb begin
        instruction_valid = w_valid;
        instruction       = NOP_WORD;
        pc_fetched        = '0;
        if (w_valid) begin
            instruction = r_fifo_data[r_fifo_rd];
            pc_fetched  = r_fifo_pc[r_fifo_rd];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Scoreboard bench for instruction_fetch_stage with a simple
//               in-order instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;

    localparam logic [31:0] c_nop = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        clear;
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instruction;
    logic [31:0] pc_fetched;
    logic        instruction_valid;
    logic        stall_pc;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk                           (clk),
        .rst                           (rst),
        .pc                            (pc),
        .pc_valid                      (pc_valid),
        .clear_instruction_fetch_stage (clear),
        .stall_instruction_fetch_stage (stall),
        .imem_req                      (imem_req),
        .imem_addr                     (imem_addr),
        .imem_gnt                      (gnt),
        .imem_rvalid                   (rvalid),
        .imem_rdata                    (rdata),
        .instruction                   (instruction),
        .pc_fetched                    (pc_fetched),
        .instruction_valid             (instruction_valid),
        .stall_programe_counter_stage  (stall_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: granted addresses in order, with a wrong-path flag each
    logic [31:0] mem_addr_q[$];
    bit          mem_kill_q[$];
    // Scoreboard of words the decode stage must receive, in order
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_data_q[$];

    bit mem_en;
    bit spurious;
    bit last_fire;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h00500093 + (a << 8);
    endfunction

    // One clock cycle: drive memory response, check at negedge, update model
    task automatic cycle();
        bit          exp_req;
        bit          fire;
        bit          hk;
        logic [31:0] ha;
        if (mem_en && mem_addr_q.size() > 0) begin
            rvalid = 1'b1;
            rdata  = mem_word(mem_addr_q[0]);
        end else if (spurious) begin
            rvalid = 1'b1;
            rdata  = 32'hDEADBEEF;
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        @(negedge clk);
        if (rst) begin
            mem_addr_q.delete();
            mem_kill_q.delete();
            exp_pc_q.delete();
            exp_data_q.delete();
        end
        exp_req = !rst && pc_valid && !clear &&
                  ((mem_addr_q.size() + exp_pc_q.size()) < 2) && (mem_addr_q.size() < 2);
        fire = exp_req && gnt;
        n_checks++;
        if (imem_req !== exp_req) begin
            n_errors++;
            $display("FAIL imem_req: got %b expected %b at %0t", imem_req, exp_req, $time);
        end
        n_checks++;
        if (stall_pc !== (pc_valid && !fire)) begin
            n_errors++;
            $display("FAIL pc_stall: got %b expected %b at %0t", stall_pc, pc_valid && !fire, $time);
        end
        if (exp_req) begin
            n_checks++;
            if (imem_addr !== pc) begin
                n_errors++;
                $display("FAIL imem_addr: got %h expected %h at %0t", imem_addr, pc, $time);
            end
        end
        n_checks++;
        if (instruction_valid !== (exp_pc_q.size() > 0)) begin
            n_errors++;
            $display("FAIL out_valid: got %b expected %b at %0t",
                     instruction_valid, exp_pc_q.size() > 0, $time);
        end else if (exp_pc_q.size() > 0) begin
            n_checks++;
            if (instruction !== exp_data_q[0] || pc_fetched !== exp_pc_q[0]) begin
                n_errors++;
                $display("FAIL out_word: got instr=%h pc=%h expected instr=%h pc=%h at %0t",
                         instruction, pc_fetched, exp_data_q[0], exp_pc_q[0], $time);
            end
            if (!stall && !clear) begin
                void'(exp_pc_q.pop_front());
                void'(exp_data_q.pop_front());
            end
        end else begin
            n_checks++;
            if (instruction !== c_nop || pc_fetched !== 32'h0) begin
                n_errors++;
                $display("FAIL out_bubble: got instr=%h pc=%h expected instr=%h pc=0 at %0t",
                         instruction, pc_fetched, c_nop, $time);
            end
        end
        if (rst) begin
            last_fire = 1'b0;
        end else begin
            if (rvalid && mem_addr_q.size() > 0) begin
                ha = mem_addr_q.pop_front();
                hk = mem_kill_q.pop_front();
                if (!hk && !clear) begin
                    exp_pc_q.push_back(ha);
                    exp_data_q.push_back(mem_word(ha));
                end
            end
            if (clear) begin
                exp_pc_q.delete();
                exp_data_q.delete();
                foreach (mem_kill_q[i]) mem_kill_q[i] = 1'b1;
            end
            if (fire) begin
                mem_addr_q.push_back(pc);
                mem_kill_q.push_back(1'b0);
            end
            last_fire = fire;
        end
        @(posedge clk);
        #1;
    endtask

    // PC stage behaviour: advance by 4 after every accepted request
    task automatic run_stream(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            if (last_fire) pc = pc + 32'd4;
        end
    endtask

    // Let everything in flight come out; bounded
    task automatic drain(input string name);
        pc_valid = 1'b0; clear = 1'b0; stall = 1'b0; gnt = 1'b1; mem_en = 1'b1; spurious = 1'b0;
        for (int i = 0; i < 20 && (exp_pc_q.size() > 0 || mem_addr_q.size() > 0); i++) cycle();
        n_checks++;
        if (exp_pc_q.size() != 0 || mem_addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: got %0d words / %0d requests left, expected 0 / 0",
                     name, exp_pc_q.size(), mem_addr_q.size());
        end
        n_checks++;
        if (instruction_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_idle: got valid=%b expected 0", name, instruction_valid);
        end
    endtask

    // Issue one fetch at address a and wait for it to appear at the output
    task automatic fetch_one(input string name, input logic [31:0] a);
        pc = a; pc_valid = 1'b1; stall = 1'b0; gnt = 1'b1; mem_en = 1'b1; clear = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (last_fire) pc_valid = 1'b0;
            if (instruction_valid === 1'b1) break;
        end
        n_checks++;
        if (instruction_valid !== 1'b1 || pc_fetched !== a) begin
            n_errors++;
            $display("FAIL %s_first: got valid=%b pc=%h expected valid=1 pc=%h",
                     name, instruction_valid, pc_fetched, a);
        end
        drain(name);
    endtask

    task automatic test_reset;
        pc = 32'h0; pc_valid = 1'b1; clear = 1'b0; stall = 1'b0; gnt = 1'b1;
        mem_en = 1'b1; spurious = 1'b0; rvalid = 1'b0; rdata = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || instruction_valid !== 1'b0 || instruction !== c_nop || pc_fetched !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_state: got req=%b valid=%b instr=%h pc=%h expected 0/0/%h/0",
                     imem_req, instruction_valid, instruction, pc_fetched, c_nop);
        end
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_first_fetch;
        pc = 32'h0; pc_valid = 1'b1; gnt = 1'b1; mem_en = 1'b1; stall = 1'b0;
        cycle();
        pc_valid = 1'b0;
        cycle();
        n_checks++;
        if (instruction_valid !== 1'b1 || instruction !== 32'h00500093 || pc_fetched !== 32'h0) begin
            n_errors++;
            $display("FAIL first_fetch: got valid=%b instr=%h pc=%h expected 1/00500093/00000000",
                     instruction_valid, instruction, pc_fetched);
        end
        drain("first");
    endtask

    task automatic test_streaming;
        pc = 32'h0; pc_valid = 1'b1; gnt = 1'b1; mem_en = 1'b1; stall = 1'b0;
        run_stream(10);
        drain("stream");
    endtask

    task automatic test_decode_stall;
        pc = 32'h0; pc_valid = 1'b1; gnt = 1'b1; mem_en = 1'b1; stall = 1'b1;
        run_stream(4);
        n_checks++;
        if (imem_req !== 1'b0 || stall_pc !== 1'b1 || instruction_valid !== 1'b1 || pc_fetched !== 32'h0) begin
            n_errors++;
            $display("FAIL stall_full: got req=%b pcstall=%b valid=%b pc=%h expected 0/1/1/00000000",
                     imem_req, stall_pc, instruction_valid, pc_fetched);
        end
        drain("stall");
    endtask

    task automatic test_grant_low;
        pc = 32'h40; pc_valid = 1'b1; gnt = 1'b0; mem_en = 1'b1; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (stall_pc !== 1'b1 || imem_addr !== 32'h40) begin
                n_errors++;
                $display("FAIL gnt_low_%0d: got pcstall=%b addr=%h expected 1/00000040",
                         i, stall_pc, imem_addr);
            end
        end
        gnt = 1'b1;
        run_stream(1);
        drain("gnt");
    endtask

    task automatic test_clear_outstanding;
        pc = 32'h10; pc_valid = 1'b1; gnt = 1'b1; mem_en = 1'b0; stall = 1'b0;
        run_stream(2);
        clear = 1'b1; pc = 32'h100;
        cycle();
        clear = 1'b0;
        cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        fetch_one("clear", 32'h100);
    endtask

    task automatic test_clear_with_rvalid;
        pc = 32'h20; pc_valid = 1'b1; gnt = 1'b1; mem_en = 1'b0; stall = 1'b1;
        run_stream(2);
        mem_en = 1'b1;
        cycle();
        n_checks++;
        if (instruction_valid !== 1'b1 || pc_fetched !== 32'h20) begin
            n_errors++;
            $display("FAIL clr_rv_pre: got valid=%b pc=%h expected 1/00000020", instruction_valid, pc_fetched);
        end
        clear = 1'b1; pc = 32'h200;
        cycle();
        clear = 1'b0;
        n_checks++;
        if (instruction_valid !== 1'b0 || instruction !== c_nop) begin
            n_errors++;
            $display("FAIL clr_rv_flush: got valid=%b instr=%h expected 0/%h", instruction_valid, instruction, c_nop);
        end
        fetch_one("clr_rv", 32'h200);
    endtask

    task automatic test_stray_rvalid;
        pc_valid = 1'b0; mem_en = 1'b1; spurious = 1'b1; stall = 1'b0;
        cycle();
        spurious = 1'b0;
        cycle();
        n_checks++;
        if (instruction_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stray_rvalid: got valid=%b expected 0", instruction_valid);
        end
        fetch_one("stray", 32'h300);
    endtask

    task automatic test_reset_midflight;
        pc = 32'h400; pc_valid = 1'b1; gnt = 1'b1; mem_en = 1'b0; stall = 1'b0;
        run_stream(2);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        n_checks++;
        if (instruction_valid !== 1'b0 || pc_fetched !== 32'h0) begin
            n_errors++;
            $display("FAIL mid_reset: got valid=%b pc=%h expected 0/00000000", instruction_valid, pc_fetched);
        end
        fetch_one("midrst", 32'h500);
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_streaming();
        test_decode_stall();
        test_grant_low();
        test_clear_outstanding();
        test_clear_with_rvalid();
        test_stray_rvalid();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
